// File: rtl/word_array_pkg.sv
// Shared types and constants for the word storage array.
package word_array_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/masked_word_reg.sv
// One storage row with per-bit write enable.
module masked_word_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (we) begin
            q <= (q & ~mask) | (d & mask);
        end
    end

endmodule

// File: rtl/word_array_ctrl.sv
// DEPTH x WIDTH scratch store: valid/ready requests, masked writes,
// registered read response and a one-word-per-cycle clear sweep.
module word_array_ctrl
    import word_array_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter int    DEPTH = 16,
    localparam int   AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             op,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] in_bus,
    input  logic [WIDTH-1:0] mask,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_bus,
    output logic             err,
    output logic             busy
);

    state_t           state;
    logic [AW-1:0]    sweep_idx;
    logic             accept;
    logic             wr_acc;
    logic             in_range;
    logic [WIDTH-1:0] rows [DEPTH];
    logic [WIDTH-1:0] rd_data;

    assign req_ready = (state == ST_IDLE) && !clear;
    assign busy      = (state == ST_CLEAR);
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && (op == OP_WRITE);
    assign in_range  = (32'(addr) < DEPTH);

    // Equality-scan mux keeps addresses past DEPTH from indexing rows.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(addr) == i) rd_data = rows[i];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_row
        masked_word_reg #(
            .WIDTH(WIDTH)
        ) u_row (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (wr_acc && (32'(addr) == g)),
            .clr  (busy && (32'(sweep_idx) == g)),
            .mask (mask),
            .d    (in_bus),
            .q    (rows[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state     <= ST_CLEAR;
                        sweep_idx <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (sweep_idx == AW'(DEPTH - 1)) begin
                        state     <= ST_IDLE;
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + AW'(1);
                    end
                end
            endcase
        end
    end

    // Writes answer only when rejected; out_bus keeps its value then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bus   <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (accept) begin
                if (!in_range) begin
                    out_valid <= 1'b1;
                    err       <= 1'b1;
                    if (op == OP_READ) out_bus <= '0;
                end else if (op == OP_READ) begin
                    out_valid <= 1'b1;
                    out_bus   <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_word_array_ctrl.sv
// Directed bench: DEPTH=16 main instance plus a DEPTH=12 instance.
module tb_word_array_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       op;
    logic [3:0] addr;
    logic [7:0] in_bus;
    logic [7:0] mask;
    logic       clear;

    logic       rdy_a, ov_a, err_a, busy_a;
    logic [7:0] ob_a;
    logic       rdy_b, ov_b, err_b, busy_b;
    logic [7:0] ob_b;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    word_array_ctrl #(.WIDTH(8), .DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_ready(rdy_a), .op(op), .addr(addr), .in_bus(in_bus),
        .mask(mask), .clear(clear), .out_valid(ov_a), .out_bus(ob_a),
        .err(err_a), .busy(busy_a)
    );

    word_array_ctrl #(.WIDTH(8), .DEPTH(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_ready(rdy_b), .op(op), .addr(addr), .in_bus(in_bus),
        .mask(mask), .clear(clear), .out_valid(ov_b), .out_bus(ob_b),
        .err(err_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle; returns at the response negedge.
    task automatic issue(input logic o, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] m);
        req_valid = 1'b1;
        op        = o;
        addr      = a;
        in_bus    = d;
        mask      = m;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; op = 1'b0; addr = '0;
        in_bus = '0; mask = '0; clear = 1'b0;

        // T1 reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(ov_a), 0);
        chk("rst_out_bus", 32'(ob_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_ready", 32'(rdy_a), 1);
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 4'(i), 8'h00, 8'h00);
            chk("t1_valid", 32'(ov_a), 1);
            chk("t1_bus", 32'(ob_a), 0);
            chk("t1_err", 32'(err_a), 0);
        end

        // T2 masked write
        issue(1'b1, 4'd3, 8'hFF, 8'hFF);
        chk("t2_wr_novalid", 32'(ov_a), 0);
        issue(1'b1, 4'd3, 8'h00, 8'h0F);
        chk("t2_wr2_novalid", 32'(ov_a), 0);
        issue(1'b0, 4'd3, 8'h00, 8'h00);
        chk("t2_rd_valid", 32'(ov_a), 1);
        chk("t2_rd_bus", 32'(ob_a), 32'h F0);

        // T3 write then read, then pipelined reads
        issue(1'b1, 4'd5, 8'hA5, 8'hFF);
        issue(1'b0, 4'd5, 8'h00, 8'h00);
        chk("t3_wr_rd", 32'(ob_a), 32'h A5);
        req_valid = 1'b1; op = 1'b0; addr = 4'd5;
        @(negedge clk);
        chk("t3_pipe0_valid", 32'(ov_a), 1);
        chk("t3_pipe0_bus", 32'(ob_a), 32'h A5);
        addr = 4'd3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t3_pipe1_valid", 32'(ov_a), 1);
        chk("t3_pipe1_bus", 32'(ob_a), 32'h F0);
        @(negedge clk);
        chk("t3_idle_valid", 32'(ov_a), 0);
        chk("t3_hold_bus", 32'(ob_a), 32'h F0);

        // T4 clear collides with a held read of addr 5
        req_valid = 1'b1; op = 1'b0; addr = 4'd5; clear = 1'b1;
        #1;
        chk("t4_ready_low", 32'(rdy_a), 0);
        @(negedge clk);
        clear = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            chk("t4_no_resp", 32'(ov_a), 0);
            chk("t4_stalled", 32'(rdy_a), 0);
            clear = (n == 5);
            @(negedge clk);
            clear = 1'b0;
        end
        chk("t4_busy_cycles", n, 16);
        chk("t4_ready_back", 32'(rdy_a), 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t4_held_valid", 32'(ov_a), 1);
        chk("t4_held_bus", 32'(ob_a), 0);
        chk("t4_held_err", 32'(err_a), 0);

        // T5 out of range on the DEPTH=12 instance
        issue(1'b0, 4'd13, 8'h00, 8'h00);
        chk("t5_rd_valid", 32'(ov_b), 1);
        chk("t5_rd_err", 32'(err_b), 1);
        chk("t5_rd_bus", 32'(ob_b), 0);
        issue(1'b1, 4'd2, 8'h3C, 8'hFF);
        chk("t5_wr_ok_novalid", 32'(ov_b), 0);
        issue(1'b0, 4'd2, 8'h00, 8'h00);
        chk("t5_rd2_bus", 32'(ob_b), 32'h 3C);
        issue(1'b1, 4'd14, 8'hFF, 8'hFF);
        chk("t5_wr_valid", 32'(ov_b), 1);
        chk("t5_wr_err", 32'(err_b), 1);
        chk("t5_wr_bus_hold", 32'(ob_b), 32'h 3C);
        for (int i = 0; i < 12; i++) begin
            issue(1'b0, 4'(i), 8'h00, 8'h00);
            chk("t5_word", 32'(ob_b), (i == 2) ? 32'h 3C : 32'h 0);
            chk("t5_word_err", 32'(err_b), 0);
        end

        // T6 reset in the middle of a sweep
        issue(1'b1, 4'd10, 8'h5A, 8'hFF);
        issue(1'b0, 4'd10, 8'h00, 8'h00);
        chk("t6_pre_bus", 32'(ob_a), 32'h 5A);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (7) @(negedge clk);
        chk("t6_mid_busy", 32'(busy_a), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy_drop", 32'(busy_a), 0);
        chk("t6_ready_up", 32'(rdy_a), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 4'(i), 8'h00, 8'h00);
            chk("t6_word_valid", 32'(ov_a), 1);
            chk("t6_word", 32'(ob_a), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
